// File: rtl/divu_unit_pkg.sv
// Shared function codes and state encoding for the
// ALU datapath and the multi-cycle unsigned divider.
package divu_unit_pkg;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } divu_state_e;

endpackage

// File: rtl/divu_step.sv
// One restoring shift-subtract iteration:
// shift {R,Q} left, subtract B when it fits.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [2*WIDTH:0] w_cat;
  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_bx;
  logic             w_ge;

  // shift the combined remainder/quotient and trial-subtract
  always_comb begin
    w_cat = {i_r, i_q} << 1;
    w_rs  = w_cat[2*WIDTH:WIDTH];
    w_bx  = {1'b0, i_b};
    w_ge  = (w_rs >= w_bx);
    o_r   = w_ge ? (w_rs - w_bx) : w_rs;
    o_q   = {w_cat[WIDTH-1:1], w_ge};
  end

endmodule

// File: rtl/divu_unit.sv
// Multi-cycle unsigned divider with its own HI/LO,
// one quotient bit per clock, MFHI/MFLO read mux.
module divu_unit
  import divu_unit_pkg::*;
#(
  parameter int         WIDTH = 32,
  parameter logic [5:0] DIVU  = FN_DIVU,
  parameter logic [5:0] MFHI  = FN_MFHI,
  parameter logic [5:0] MFLO  = FN_MFLO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  divu_state_e      r_state;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  divu_state_e      w_nxt_state;
  logic [WIDTH:0]   w_nxt_r;
  logic [WIDTH-1:0] w_nxt_q;
  logic [WIDTH-1:0] w_nxt_b;
  logic [CW-1:0]    w_nxt_cnt;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;
  logic             w_nxt_dbz;

  logic [WIDTH:0]   w_step_r;
  logic [WIDTH-1:0] w_step_q;
  logic             w_start;

  divu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r(r_r),
    .i_q(r_q),
    .i_b(r_b),
    .o_r(w_step_r),
    .o_q(w_step_q)
  );

  // state, working registers and HI/LO; reset aborts anything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_r     <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_r     <= w_nxt_r;
      r_q     <= w_nxt_q;
      r_b     <= w_nxt_b;
      r_cnt   <= w_nxt_cnt;
      r_hi    <= w_nxt_hi;
      r_lo    <= w_nxt_lo;
      r_dbz   <= w_nxt_dbz;
    end
  end

  // next-state: accept DIVU outside CALC, iterate, commit on last step
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_r     = r_r;
    w_nxt_q     = r_q;
    w_nxt_b     = r_b;
    w_nxt_cnt   = r_cnt;
    w_nxt_hi    = r_hi;
    w_nxt_lo    = r_lo;
    w_nxt_dbz   = r_dbz;
    w_start     = (Signal == DIVU);
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (w_start) begin
          w_nxt_state = S_CALC;
          w_nxt_r     = '0;
          w_nxt_q     = dataA;
          w_nxt_b     = dataB;
          w_nxt_cnt   = '0;
          w_nxt_dbz   = 1'b0;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_CALC: begin
        busy      = 1'b1;
        w_nxt_r   = w_step_r;
        w_nxt_q   = w_step_q;
        w_nxt_cnt = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_nxt_state = S_DONE;
          w_nxt_lo    = w_step_q;
          w_nxt_hi    = w_step_r[WIDTH-1:0];
          w_nxt_dbz   = (r_b == '0);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // register read-back for MFHI/MFLO, zero otherwise
  always_comb begin
    dataOut = '0;
    unique case (1'b1)
      (Signal == MFHI): dataOut = r_hi;
      (Signal == MFLO): dataOut = r_lo;
      default: dataOut = '0;
    endcase
  end

  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divu_unit.sv
// Self-checking bench for divu_unit: vector table,
// hand-written corner sequences and random vs. model.
module tb_divu_unit;

  localparam logic [5:0] S_DIVU = 6'b011011;
  localparam logic [5:0] S_MFHI = 6'b010000;
  localparam logic [5:0] S_MFLO = 6'b010010;
  localparam logic [5:0] S_NOP  = 6'b111111;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks;
  int failures;

  divu_unit dut (
    .clk(clk),
    .reset(reset),
    .dataA(dataA),
    .dataB(dataB),
    .Signal(Signal),
    .dataOut(dataOut),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // issue DIVU for one edge; returns #1 after the accepting edge
  task automatic start_div(input logic [31:0] a,
                           input logic [31:0] b);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = S_DIVU;
    @(posedge clk);
    #1;
    Signal = S_NOP;
  endtask

  // count busy cycles until busy drops, bounded
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 100) chk("timeout", 32'(n), 32'd32);
  endtask

  task automatic read_hilo(input string nm,
                           input logic [31:0] lo,
                           input logic [31:0] hi);
    Signal = S_MFLO;
    #1;
    chk({nm, ".lo"}, dataOut, lo);
    Signal = S_MFHI;
    #1;
    chk({nm, ".hi"}, dataOut, hi);
    Signal = S_NOP;
  endtask

  task automatic full_div(input string nm,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] lo,
                          input logic [31:0] hi,
                          input logic dbz);
    int n;
    start_div(a, b);
    chk({nm, ".busy0"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({nm, ".lat"}, 32'(n), 32'd32);
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".dbz"}, 32'(div_by_zero), 32'(dbz));
    read_hilo(nm, lo, hi);
    @(posedge clk);
    #1;
    chk({nm, ".done_off"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    logic [31:0] a, b, q, r;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    dataA    = '0;
    dataB    = '0;
    Signal   = S_NOP;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    vecs[3] = '{32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345, 1'b1};
    vecs[4] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    vecs[5] = '{32'd5, 32'd10, 32'd0, 32'd5, 1'b0};
    vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    vecs[7] = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1};
    vecs[8] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1};
    vecs[9] = '{32'h8000_0000, 32'd2, 32'h4000_0000, 32'd0, 1'b0};

    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.dbz", 32'(div_by_zero), 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      full_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
               vecs[i].lo, vecs[i].hi, vecs[i].dbz);

    // DIVU during CALC is ignored
    start_div(32'd9, 32'd4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    dataA  = 32'd40;
    dataB  = 32'd6;
    Signal = S_DIVU;
    @(posedge clk);
    #1;
    Signal = S_NOP;
    wait_done(n);
    chk("ign.lat", 32'(n), 32'd26);
    read_hilo("ign", 32'd2, 32'd1);
    @(posedge clk);
    #1;
    chk("ign.busy_after", 32'(busy), 32'd0);
    chk("ign.done_after", 32'(done), 32'd0);

    // stale read mid-CALC
    full_div("s1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    start_div(32'd50, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    Signal = S_MFLO;
    #1;
    chk("stale.lo", dataOut, 32'd14);
    Signal = S_NOP;
    wait_done(n);
    read_hilo("fresh", 32'd10, 32'd0);

    // back-to-back: DIVU accepted in the DONE cycle
    start_div(32'd77, 32'd0);
    wait_done(n);
    chk("b2b.done", 32'(done), 32'd1);
    chk("b2b.dbz1", 32'(div_by_zero), 32'd1);
    dataA  = 32'd1000;
    dataB  = 32'd7;
    Signal = S_DIVU;
    @(posedge clk);
    #1;
    Signal = S_NOP;
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.dbz_clr", 32'(div_by_zero), 32'd0);
    read_hilo("b2b.old", 32'hFFFF_FFFF, 32'd77);
    wait_done(n);
    chk("b2b.lat", 32'(n), 32'd32);
    read_hilo("b2b.new", 32'd142, 32'd6);

    // reset at iteration 10
    start_div(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    reset  = 1'b0;
    Signal = S_MFLO;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.lo", dataOut, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) n++;
    end
    chk("abort.no_done", 32'(n), 32'd0);
    read_hilo("abort.after", 32'd0, 32'd0);

    // random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = a >> $urandom_range(0, 4);
      endcase
      ref_div(a, b, q, r);
      full_div($sformatf("rnd%0d", i), a, b, q, r, (b == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divu_unit.md
Name: divu_unit

Overview:
- Multi-cycle unsigned divider; the inverse partner of the existing MULTU multiplier path.
- Executes DIVU (Signal = 6'b011011) as a restoring shift-subtract, one quotient bit per clock.
- Writes quotient into its own LO and remainder into its own HI, following the MIPS HI/LO convention.
- Serves MFHI/MFLO reads, so the ALU top can mux dataOut alongside the existing MUX outputs.

Parameters:
- WIDTH, 32: operand, quotient and remainder width.
- DIVU, 6'b011011: function code that launches a divide.
- MFHI, 6'b010000: function code that reads the remainder.
- MFLO, 6'b010010: function code that reads the quotient.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- dataA  in  WIDTH  dividend, sampled when DIVU is accepted.
- dataB  in  WIDTH  divisor, sampled when DIVU is accepted.
- Signal  in  6  function code.
- dataOut  out  WIDTH  HI when Signal=MFHI, LO when Signal=MFLO, else 0.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when a new HI/LO has been written.
- div_by_zero  out  1  set on completion if the latched divisor was 0; cleared on the next accepted DIVU.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; HI, LO, working registers and counter = 0.
  - busy=0, done=0, div_by_zero=0, dataOut=0.
- States: IDLE, CALC, DONE.
- IDLE or DONE, Signal==DIVU at edge E0:
  - latch divisor B<=dataB, Q<=dataA, partial remainder R<=0, count<=0.
  - clear div_by_zero; go to CALC.
- Signal==DIVU in CALC is ignored. No queueing; the current operation continues unaffected.
- CALC, each edge:
  - {R,Q} shift left 1 (WIDTH+1-bit R datapath).
  - If shifted R >= B: R<=R-B and Q[0]<=1; else Q[0]<=0.
  - count<=count+1.
- Latency:
  - iterations on edges E1..E32.
  - on E32: LO<=final Q, HI<=final R, div_by_zero<=(B==0), state->DONE.
- DONE: lasts exactly one cycle with done=1, then IDLE (or CALC if DIVU is accepted in that cycle).
- busy=1 exactly while state==CALC (32 cycles). done=1 exactly while state==DONE.
- Divisor 0: no special path. The algorithm naturally yields LO=all ones and HI=dividend, with the same latency. div_by_zero=1.
- Dividend < divisor: LO=0, HI=dividend.
- HI/LO are written only on completion. MFHI/MFLO during CALC return the previous result (stale by design).
- dataOut is a combinational mux from the HI/LO registers on the current Signal, with no added latency.
- Reset mid-operation: immediate abort to IDLE; HI/LO cleared; no done pulse.
- Simultaneous DIVU acceptance in DONE: done still pulses for the finishing result; the new operation starts that edge.

Decomposition:
- Shared package holds the function-code constants (DIVU, MFHI, MFLO, plus existing AND/OR/ADD/SUB/SLT/SLL/MULTU) and the state encoding.
- One natural sub-module: divu_step, the combinational single iteration. Inputs {R,Q,B}; outputs {R',Q'}.
- The FSM, counter and HI/LO registers stay in divu_unit.

Test Plan:
- 100 / 7 -> after DIVU, busy high 32 cycles, done pulses at cycle 33; MFLO=14, MFHI=2, div_by_zero=0.
- 0xFFFFFFFF / 1 -> LO=0xFFFFFFFF, HI=0; then 0xFFFFFFFF / 0xFFFFFFFF -> LO=1, HI=0.
- 12345 / 0 -> LO=0xFFFFFFFF, HI=12345, div_by_zero=1; next DIVU 9/3 clears the flag, giving LO=3, HI=0.
- 5 / 10 -> LO=0, HI=5. Then issue DIVU 40/6 during CALC of a 9/4 divide -> second command ignored; result LO=2, HI=1 only.
- Start 1000/3, assert reset=0 at iteration 10 -> busy, done and HI/LO drop to 0 immediately; after release, MFLO=0.
- After 100/7 completes, start 50/5 and read MFLO mid-CALC -> 14 (stale); after done, MFLO=10.
